// File: rtl/seg_pkg.sv
// Shared seven-segment constants, FSM state type and pattern lookup.
// Used by both the encoder and the decoder side of the board link.
package seg_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h20;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {IDLE, ACQUIRE, HOLD} seg_state_t;

   // Returns {valid, value}; BLANK and unknown patterns both come back invalid.
   function automatic logic [4:0] seg_lookup(input logic [6:0] pat);
      logic [4:0] res;
      case (pat)
         SEG_0:   res = 5'h10;
         SEG_1:   res = 5'h11;
         SEG_2:   res = 5'h12;
         SEG_3:   res = 5'h13;
         SEG_4:   res = 5'h14;
         SEG_5:   res = 5'h15;
         SEG_6:   res = 5'h16;
         SEG_7:   res = 5'h17;
         SEG_8:   res = 5'h18;
         SEG_9:   res = 5'h19;
         SEG_A:   res = 5'h1A;
         SEG_B:   res = 5'h1B;
         SEG_C:   res = 5'h1C;
         SEG_D:   res = 5'h1D;
         SEG_E:   res = 5'h1E;
         SEG_F:   res = 5'h1F;
         default: res = 5'h00;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/seg_sync.sv
// Two-flop synchroniser with a caller-supplied reset value.
module seg_sync #(
   parameter int W = 7
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] rst_val,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= rst_val;
         q    <= rst_val;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/seg_decoder.sv
// Seven-segment receive decoder: synchronise, stability-filter, decode to hex.
// Optional SEG_DEC_HIST_EN adds a 4-deep history of decoded digits on hist.
//
// state   | meaning
// IDLE    | out of reset, waiting for first change or a stable reset pattern
// ACQUIRE | sample changed, waiting for STABLE_CYCLES identical samples
// HOLD    | stable pattern classified, waiting for the next change
module seg_decoder
   import seg_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  seg_in,
   output logic [3:0]  digit,
   output logic        digit_valid,
   output logic        seg_err,
   output logic        locked
`ifdef SEG_DEC_HIST_EN
   ,
   output logic [15:0] hist
`endif
);

   localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

   logic [6:0] seg_s;
   logic [6:0] seg_prev;
   logic [7:0] cnt;
   logic       same;
   logic       sat;
   logic [4:0] lut;
   seg_state_t state;

   seg_sync #(.W(7)) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .rst_val (SEG_BLANK),
      .d       (seg_in),
      .q       (seg_s)
   );

   assign same = (seg_s == seg_prev);
   assign sat  = (cnt == CNT_MAX);
   assign lut  = seg_lookup(seg_s);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_prev    <= SEG_BLANK;
         cnt         <= '0;
         state       <= IDLE;
         digit       <= '0;
         digit_valid <= 1'b0;
         seg_err     <= 1'b0;
         locked      <= 1'b0;
`ifdef SEG_DEC_HIST_EN
         hist        <= '0;
`endif
      end else begin
         seg_prev    <= seg_s;
         digit_valid <= 1'b0;
         seg_err     <= 1'b0;

         if (!same)
            cnt <= '0;
         else if (!sat)
            cnt <= cnt + 8'd1;

         case (state)
            IDLE, ACQUIRE: begin
               if (!same) begin
                  state <= ACQUIRE;
               end else if (sat) begin
                  // Classified exactly once per acquisition; HOLD suppresses repeats.
                  state <= HOLD;
                  if (lut[4]) begin
                     digit       <= lut[3:0];
                     digit_valid <= 1'b1;
                     locked      <= 1'b1;
`ifdef SEG_DEC_HIST_EN
                     hist        <= {hist[11:0], lut[3:0]};
`endif
                  end else begin
                     locked  <= 1'b0;
                     seg_err <= (seg_s != SEG_BLANK);
                  end
               end
            end
            HOLD: begin
               if (!same) begin
                  state  <= ACQUIRE;
                  locked <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seg_decoder.sv
// Self-checking bench for seg_decoder: directed pattern table plus hand sequences.
module tb_seg_decoder;

   localparam int SC = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  seg_in = 7'h7F;
   logic [3:0]  digit;
   logic        digit_valid;
   logic        seg_err;
   logic        locked;
`ifdef SEG_DEC_HIST_EN
   logic [15:0] hist;
`endif

   int errors = 0;
   int checks = 0;
   int both_hi = 0;

   always #5 clk = ~clk;

   seg_decoder #(.STABLE_CYCLES(SC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg_in      (seg_in),
      .digit       (digit),
      .digit_valid (digit_valid),
      .seg_err     (seg_err),
      .locked      (locked)
`ifdef SEG_DEC_HIST_EN
      ,
      .hist        (hist)
`endif
   );

   typedef struct {
      logic [6:0] seg;
      int         hold;
      int         n_valid;
      int         n_err;
      int         exp_digit;
      int         exp_locked;
   } vec_t;

   vec_t vt[20];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Drive a pattern before edge 0 and observe it for 'cycles' edges.
   task automatic run_pattern(input logic [6:0] s, input int cycles,
                              output int nv, output int ne, output int first_edge,
                              output int lock_drops, output int lock_low);
      logic acquired;
      nv = 0; ne = 0; first_edge = -1; lock_drops = 0; lock_low = 0;
      acquired = 1'b0;
      @(negedge clk);
      seg_in = s;
      for (int k = 0; k < cycles; k++) begin
         @(posedge clk);
         #1;
         if (digit_valid && seg_err) both_hi++;
         if (digit_valid || seg_err) begin
            if (first_edge < 0) first_edge = k;
         end
         if (digit_valid) begin
            nv++;
            acquired = 1'b1;
         end else if (acquired && !locked) begin
            lock_drops++;
         end
         if (seg_err) ne++;
         if (!locked) lock_low++;
      end
   endtask

   initial begin
      int nv, ne, fe, ld, ll;
      string nm;

      vt[0]  = '{7'h40, 12, 1, 0, 4'h0, 1};
      vt[1]  = '{7'h79, 12, 1, 0, 4'h1, 1};
      vt[2]  = '{7'h24, 12, 1, 0, 4'h2, 1};
      vt[3]  = '{7'h30, 12, 1, 0, 4'h3, 1};
      vt[4]  = '{7'h19, 12, 1, 0, 4'h4, 1};
      vt[5]  = '{7'h12, 12, 1, 0, 4'h5, 1};
      vt[6]  = '{7'h02, 12, 1, 0, 4'h6, 1};
      vt[7]  = '{7'h78, 12, 1, 0, 4'h7, 1};
      vt[8]  = '{7'h00, 12, 1, 0, 4'h8, 1};
      vt[9]  = '{7'h10, 12, 1, 0, 4'h9, 1};
      vt[10] = '{7'h20, 12, 1, 0, 4'hA, 1};
      vt[11] = '{7'h03, 12, 1, 0, 4'hB, 1};
      vt[12] = '{7'h46, 12, 1, 0, 4'hC, 1};
      vt[13] = '{7'h21, 12, 1, 0, 4'hD, 1};
      vt[14] = '{7'h06, 12, 1, 0, 4'hE, 1};
      vt[15] = '{7'h0E, 12, 1, 0, 4'hF, 1};
      vt[16] = '{7'h12, 30, 1, 0, 4'h5, 1};
      vt[17] = '{7'h7E, 12, 0, 1, 4'h5, 0};
      vt[18] = '{7'h7F, 20, 0, 0, 4'h5, 0};
      vt[19] = '{7'h79, 12, 1, 0, 4'h1, 1};

      // Reset state, then blank held from reset: nothing may be emitted.
      repeat (2) @(negedge clk);
      check("reset_digit", int'(digit), 0);
      check("reset_valid", int'(digit_valid), 0);
      check("reset_err", int'(seg_err), 0);
      check("reset_locked", int'(locked), 0);
      rst_n = 1'b1;
      run_pattern(7'h7F, 20, nv, ne, fe, ld, ll);
      check("blank_valid_cnt", nv, 0);
      check("blank_err_cnt", ne, 0);
      check("blank_locked_low", ll, 20);

      for (int i = 0; i < 20; i++) begin
         run_pattern(vt[i].seg, vt[i].hold, nv, ne, fe, ld, ll);
         nm = $sformatf("vec%0d_seg%02h", i, vt[i].seg);
         check({nm, "_valid_cnt"}, nv, vt[i].n_valid);
         check({nm, "_err_cnt"}, ne, vt[i].n_err);
         check({nm, "_digit"}, int'(digit), vt[i].exp_digit);
         check({nm, "_locked"}, int'(locked), vt[i].exp_locked);
         if (vt[i].n_valid + vt[i].n_err > 0)
            check({nm, "_latency"}, fe, 2 + SC);
         if (vt[i].n_valid > 0)
            check({nm, "_lock_drops"}, ld, 0);
      end

      // Glitch: locked on 0, 79 for two cycles, back to 40.
      run_pattern(7'h40, 12, nv, ne, fe, ld, ll);
      check("glitch_pre_locked", int'(locked), 1);
      check("glitch_pre_digit", int'(digit), 0);
      run_pattern(7'h79, 2, nv, ne, fe, ld, ll);
      check("glitch_mid_valid_cnt", nv, 0);
      run_pattern(7'h40, 14, nv, ne, fe, ld, ll);
      check("glitch_reemit_cnt", nv, 1);
      check("glitch_err_cnt", ne, 0);
      check("glitch_locked_dropped", int'(ll > 0), 1);
      check("glitch_digit", int'(digit), 0);
      check("glitch_locked_end", int'(locked), 1);

      // Reset mid-acquisition of 12 aborts it; after release 12 decodes at edge 6.
      run_pattern(7'h12, 3, nv, ne, fe, ld, ll);
      check("rst_pre_valid_cnt", nv, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid_digit", int'(digit), 0);
      check("rst_mid_valid", int'(digit_valid), 0);
      check("rst_mid_err", int'(seg_err), 0);
      check("rst_mid_locked", int'(locked), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      nv = 0; fe = -1;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         if (digit_valid) begin
            nv++;
            if (fe < 0) fe = k;
         end
      end
      check("rst_release_valid_cnt", nv, 1);
      check("rst_release_latency", fe, 2 + SC);
      check("rst_release_digit", int'(digit), 5);

`ifdef SEG_DEC_HIST_EN
      begin
         int tot;
         tot = 0;
         run_pattern(7'h79, 10, nv, ne, fe, ld, ll); tot += nv;
         run_pattern(7'h24, 10, nv, ne, fe, ld, ll); tot += nv;
         run_pattern(7'h30, 10, nv, ne, fe, ld, ll); tot += nv;
         run_pattern(7'h19, 10, nv, ne, fe, ld, ll); tot += nv;
         check("hist_pulses", tot, 4);
         check("hist_value", int'(hist), 16'h1234);
         run_pattern(7'h7E, 10, nv, ne, fe, ld, ll);
         check("hist_after_err", int'(hist), 16'h1234);
      end
`endif

      check("valid_err_exclusive", both_hi, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg_decoder.md
# seg_decoder

Receive-side counterpart of the board's hex-to-seven-segment encoder. The block samples an asynchronous, active-low 7-segment pattern bus, filters glitches with a stability window, and decodes each stable pattern back to its 4-bit hex value. It emits a one-cycle valid or error pulse for each newly acquired pattern. It sits between a display-pattern source (switches, GPIO header, or another board's HEX pins) and downstream logic that needs the numeric digit.

## Interface
- STABLE_CYCLES, 4, number of consecutive identical synchronised samples required before decoding. Legal range is 1..255.
- clk  input  1  single system clock. All logic is on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- seg_in  input  7  asynchronous pattern, active-low. Bit 0 = segment a … bit 6 = segment g.
- digit  output  4  last successfully decoded value.
- digit_valid  output  1  one-cycle pulse when a valid pattern is acquired.
- seg_err  output  1  one-cycle pulse when a stable pattern is not in the table.
- locked  output  1  level; high while the currently held stable pattern is valid.
- hist  output  16  last four decoded digits, newest in [3:0]. Present only with SEG_DEC_HIST_EN.

## Operation
- Decode table (seg_in hex → digit):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7
  - 00→8, 10→9, 20→A, 03→b, 46→C, 21→d, 06→E, 0E→F
- Pattern 7F (all segments off) is BLANK. Any other value is invalid.
- seg_in passes through a 2-flop synchroniser. Both stages reset to 7F.
- A stability counter compares the synchronised sample with the previous sample:
  - On mismatch: counter ← 0.
  - On match: counter increments, saturating at STABLE_CYCLES-1. It never wraps.
- State machine:
  - IDLE: entered from reset. On first sample change, or on counter saturation of the reset value 7F, go to ACQUIRE/HOLD as below.
  - ACQUIRE: `locked` = 0. When the counter reaches STABLE_CYCLES-1 with an unchanged sample, go to HOLD and classify the sample once:
    - valid → `digit` updated, `digit_valid` pulses, `locked` ← 1.
    - invalid → `seg_err` pulses, `digit` retained, `locked` ← 0.
    - BLANK → no pulse, `locked` ← 0.
  - HOLD: no pulses while the sample is unchanged. On any sample change, go to ACQUIRE and drop `locked` on the same edge.
- Glitch rule: a sample change shorter than the stability window produces no decode. When the pattern returns, it is re-acquired and re-emitted, including when it equals the previous HOLD value.
- `digit_valid` and `seg_err` are mutually exclusive.
- Reset values: `digit` = 0, `digit_valid` = 0, `seg_err` = 0, `locked` = 0, `hist` = 0, counter = 0, state = IDLE.
- Reset asserted mid-acquisition aborts it with no pulse.

## Timing
- Latency: seg_in changes before rising edge 0 and is held. The pulse is registered at edge 2+STABLE_CYCLES and is high for exactly one cycle. With the default STABLE_CYCLES = 4, that is edge 6.
- STABLE_CYCLES = 1: a decode occurs on the first edge at which the synchronised sample differs from its predecessor and is then seen once more, i.e. edge 3.
- `locked` rises on the same edge as `digit_valid`. It falls on the edge at which the sample change is detected, one edge after the change reaches the second synchroniser stage.
- `digit` and `hist` change only on `digit_valid` edges.
- All outputs are registered; there are no combinational paths from seg_in.

## Configuration
- SEG_DEC_HIST_EN defined:
  - `hist` is present.
  - On each `digit_valid`: `hist` ← {hist[11:0], new digit}.
  - `seg_err` and BLANK leave `hist` unchanged.
- Not defined: no `hist` port or register. All other behaviour is identical.

## Structure
- Shared package seg_pkg:
  - localparams for the 16 patterns and SEG_BLANK = 7'h7F.
  - state enum {IDLE, ACQUIRE, HOLD}.
  - a pattern→digit lookup function returning {valid, value}.
- The encoder side shares these constants from the same package.
- One sub-module: seg_sync, a parameterised-width 2-flop synchroniser with reset value input. seg_decoder instantiates it at width 7 with value 7F.

## Test plan
- Reset: rst_n low while seg_in = 12 mid-window → all outputs 0. After release with seg_in = 12 held, `digit_valid` pulses 6 edges later.
- Valid hold: seg_in = 12 held for 30 cycles → exactly one `digit_valid`, `digit` = 5, `locked` = 1 throughout HOLD.
- Glitch: locked on 40, drive 79 for 2 cycles, then 40 again → no pulse carrying `digit` = 1, `locked` low during the disturbance, one re-emitted pulse with `digit` = 0.
- Invalid: after `digit` = 5, hold seg_in = 7E → one `seg_err` pulse, `locked` = 0, `digit` stays 5.
- Blank: hold seg_in = 7F for 20 cycles → no `digit_valid`, no `seg_err`, `locked` = 0.
- History (SEG_DEC_HIST_EN): hold 79, 24, 30, 19 for 10 cycles each → four pulses, `hist` = 16'h1234.
